// File: rtl/rom_loader_if.sv
// Load-stream handshake between an external image source and rom_loader.
// The master drives words in; the slave (the loader) answers with s_ready.
interface rom_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/rom_loader.sv
// Boot-time instruction ROM writer: streams an image in from address 0, holds the core in reset meanwhile.
// Optional ecall fill of the unused ROM tail is built when ROM_LOADER_FILL_EN is defined.
module rom_loader #(
    parameter int          ROM_DEPTH = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] FILL_WORD = 32'h0000_0073
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_loader_if.slave       load,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {LOAD, FILL, RUN, ERR} state_t;

    // cnt carries one extra bit so the top-address compare can never alias onto a wrapped value.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(ROM_DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [31:0]       wdata_nxt;
    logic              accept;

    // Gated by rst_n so the source never sees ready while the loader is held in reset.
    assign load.s_ready = rst_n && (state == LOAD);
    assign accept       = load.s_valid && load.s_ready;

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = 1'b0;
        waddr_nxt = rom_waddr;
        wdata_nxt = rom_wdata;

        case (state)
            LOAD: begin
                if (accept) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = cnt[ADDR_W-1:0];
                    wdata_nxt = load.s_data;
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_nxt = load.s_last ? RUN : ERR;
                    end else if (load.s_last) begin
`ifdef ROM_LOADER_FILL_EN
                        state_nxt = FILL;
`else
                        state_nxt = RUN;
`endif
                    end
                end
            end
            // Only reachable when the fill option is built in.
            FILL: begin
                we_nxt    = 1'b1;
                waddr_nxt = cnt[ADDR_W-1:0];
                wdata_nxt = FILL_WORD;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            rom_we     <= 1'b0;
            rom_waddr  <= '0;
            rom_wdata  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rom_we     <= we_nxt;
            rom_waddr  <= waddr_nxt;
            rom_wdata  <= wdata_nxt;
            // Core release lags entry to RUN by one cycle, after the final ROM write has landed.
            core_rst_n <= (state == RUN);
            done       <= (state == RUN);
            err        <= (state == ERR);
        end
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time instruction-memory writer for the RV32IM SoC. Accepts a valid/ready stream of 32-bit instruction words, writes them into the instruction ROM from word address 0 upward, and optionally fills the rest of the ROM with `ecall` (0x00000073). It holds the core in reset until loading completes, then releases it. It sits in `soc_top` between an external load port and the write port of `u_rom`, and drives the core's reset input.

## Interface
- `ROM_DEPTH`, 1024: number of 32-bit ROM words (≥2).
- `ADDR_W`, 10: word-address width; must satisfy 2^ADDR_W ≥ ROM_DEPTH.
- `FILL_WORD`, 32'h00000073: fill pattern (`ecall`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  load word present.
- `s_data`  in  32  instruction word.
- `s_last`  in  1  marks the final word of the image.
- `s_ready`  out  1  loader accepts a word this cycle.
- `rom_we`  out  1  ROM write strobe (registered).
- `rom_waddr`  out  ADDR_W  ROM word address (registered).
- `rom_wdata`  out  32  ROM write data (registered).
- `core_rst_n`  out  1  core reset, active-low (registered).
- `done`  out  1  image loaded; core running.
- `err`  out  1  image overflowed the ROM.

## Operation
- States: LOAD, FILL, RUN, ERR. Reset enters LOAD with `cnt`=0.
- LOAD:
  - `s_ready`=1.
  - An accept is `s_valid & s_ready` at a clock edge.
  - Each accept registers `rom_we`=1, `rom_waddr`=cnt, `rom_wdata`=s_data, then increments cnt.
  - Accept with `s_last`=1 at cnt<ROM_DEPTH-1: go to FILL, or to RUN when fill is compiled out.
  - Accept with `s_last`=1 at cnt=ROM_DEPTH-1: go to RUN, since the ROM is exactly full.
  - Accept with `s_last`=0 at cnt=ROM_DEPTH-1: the word is written, then go to ERR.
- FILL:
  - `s_ready`=0.
  - Writes FILL_WORD at cnt, one word per cycle, incrementing cnt.
  - After writing address ROM_DEPTH-1, go to RUN.
- RUN:
  - `s_ready`=0, `rom_we`=0.
  - `done`=1 and `core_rst_n`=1 are held until `rst_n` is asserted.
- ERR:
  - `s_ready`=0, `rom_we`=0, `err`=1.
  - `core_rst_n` is held at 0. Exit only by `rst_n`.
- No-valid cycles in LOAD produce no write and no state change.
- `s_data` and `s_last` are ignored when no accept occurs.
- `rst_n` asserted at any time, including mid-LOAD or mid-FILL, aborts the sequence. ROM contents already written are left as-is; the next load overwrites from address 0.
- cnt is ADDR_W+1 bits wide so the ROM_DEPTH compare never wraps. `rom_waddr` is cnt[ADDR_W-1:0].

## Timing
- Reset values: `s_ready`=0 during reset and 1 in the first cycle after `rst_n` deasserts; `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0, `core_rst_n`=0, `done`=0, `err`=0.
- Write latency: an accept at edge N gives `rom_we`/`rom_waddr`/`rom_wdata` valid during cycle N→N+1. The ROM captures the word at edge N+1.
- Throughput: one word per cycle when `s_valid` is held high.
- FILL begins the cycle after the last data write. Its writes are contiguous, with no gaps.
- `core_rst_n` and `done` rise in the cycle after the final ROM write cycle, so the ROM holds the complete image before the core fetches.
- Example with fill: K words, last accepted at edge N. Data writes run to cycle N; fill writes cover ROM_DEPTH−K cycles. `core_rst_n`=1 from edge N+1+(ROM_DEPTH−K).
- Example without fill: last accepted at edge N; `core_rst_n`=1 from edge N+1.
- `err` rises at edge N+1 after the overflowing accept.

## Configuration
- `ROM_LOADER_FILL_EN`
- Defined: the FILL state is present. Unused words receive FILL_WORD, so a stray PC traps on `ecall`.
- Undefined: no FILL state. LOAD on `s_last` goes directly to RUN, and unwritten words keep prior contents.

## Test plan
- Fill enabled, ROM_DEPTH=32: stream 22 words (word i = 0x100+i, last on i=21), `s_valid` held high → ROM[0..21]=0x100..0x115; ROM[22..31]=0x00000073; `core_rst_n` rises exactly 32 cycles after the first accept; `done`=1, `err`=0.
- Same stream with `s_valid` toggling every other cycle → identical ROM contents; no write on idle cycles; `rom_waddr` strictly sequential.
- ROM_DEPTH=32, 32 words with last on word 31 → no fill writes; RUN in the cycle after word 31 is written; `done`=1.
- ROM_DEPTH=32, 33 words with no `s_last` → ROM[0..31] written; `err`=1 one cycle after accept 32; `s_ready`=0; `core_rst_n` stays 0; word 33 not accepted.
- `rst_n` pulsed low for 1 cycle after 10 words accepted, then a 4-word reload (0xA0..0xA3) → writes restart at address 0; ROM[0..3]=0xA0..0xA3; all outputs at reset values during the reset cycle.
- Macro undefined, ROM pre-set to 0xDEADBEEF, 4 words loaded → ROM[4..31]=0xDEADBEEF; `core_rst_n`=1 one cycle after the 4th write.
